// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, issues at most one data-cache
// request per load/store, extends load data and drains responses orphaned by a flush.
module mem_stage (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        left_valid_i,
    output logic        left_ready_o,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_inst_i,
    input  logic        ex_wreg_en_i,
    input  logic [4:0]  ex_wreg_index_i,
    input  logic [31:0] ex_result_i,
    input  logic [2:0]  ex_ld_op_i,
    input  logic [1:0]  ex_st_op_i,
    input  logic [31:0] ex_st_data_i,
    input  logic        ex_excp_i,
    output logic        dreq_valid_o,
    input  logic        dreq_ready_i,
    output logic        dreq_we_o,
    output logic [31:0] dreq_addr_o,
    output logic [3:0]  dreq_wstrb_o,
    output logic [31:0] dreq_wdata_o,
    input  logic        dresp_valid_i,
    input  logic [31:0] dresp_rdata_i,
    output logic        right_valid_o,
    input  logic        right_ready_i,
    output logic [31:0] mem_pc_o,
    output logic [31:0] mem_inst_o,
    output logic        mem_wreg_en_o,
    output logic [4:0]  mem_wreg_index_o,
    output logic [31:0] mem_result_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_ale_o,
    output logic        mem_excp_o
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d, result_q, result_d, addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  wreg_index_q, wreg_index_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  ld_op_q, ld_op_d;
    logic        wreg_en_q, wreg_en_d, ale_q, ale_d, excp_q, excp_d, we_q, we_d;

    logic        capture, is_ld, is_st, is_h, is_w, ale, cap_mem;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Decode of the incoming EX instruction
    always_comb begin
        is_ld    = (ex_ld_op_i != 3'd0) && (ex_ld_op_i <= 3'd5);
        is_st    = (ex_st_op_i != 2'd0);
        is_h     = (ex_ld_op_i == 3'd2) || (ex_ld_op_i == 3'd5) || (ex_st_op_i == 2'd2);
        is_w     = (ex_ld_op_i == 3'd3) || (ex_st_op_i == 2'd3);
        ale      = (is_h && ex_result_i[0]) || (is_w && (ex_result_i[1:0] != 2'b00));
        cap_mem  = (is_ld || is_st) && !ex_excp_i && !ale;
        st_wstrb = 4'b0000;
        st_wdata = 32'h0;
        unique case (ex_st_op_i)
            2'd1: begin
                st_wstrb = 4'b0001 << ex_result_i[1:0];
                st_wdata = {4{ex_st_data_i[7:0]}};
            end
            2'd2: begin
                st_wstrb = ex_result_i[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_st_data_i[15:0]}};
            end
            2'd3: begin
                st_wstrb = 4'b1111;
                st_wdata = ex_st_data_i;
            end
            default: ;
        endcase
    end

    // Load extraction from the returned word
    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    ld_byte = dresp_rdata_i[7:0];
            2'd1:    ld_byte = dresp_rdata_i[15:8];
            2'd2:    ld_byte = dresp_rdata_i[23:16];
            default: ld_byte = dresp_rdata_i[31:24];
        endcase
        ld_half = addr_q[1] ? dresp_rdata_i[31:16] : dresp_rdata_i[15:0];
        unique case (ld_op_q)
            3'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd3:    ld_data = dresp_rdata_i;
            3'd4:    ld_data = {24'h0, ld_byte};
            3'd5:    ld_data = {16'h0, ld_half};
            default: ld_data = result_q;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            // Any request the cache has accepted must have its response swallowed
            if ((state_q == StWait  && !dresp_valid_i) ||
                (state_q == StReq   && dreq_ready_i)   ||
                (state_q == StDrain && !dresp_valid_i)) state_d = StDrain;
            else                                        state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (capture) state_d = cap_mem ? StReq : StHold;
                StReq:   if (dreq_ready_i) state_d = StWait;
                StWait:  if (dresp_valid_i) state_d = StHold;
                StHold:  if (right_ready_i) state_d = capture ? (cap_mem ? StReq : StHold) : StIdle;
                StDrain: if (dresp_valid_i) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        left_ready_o  = !flush_i && (state_q == StIdle || (state_q == StHold && right_ready_i));
        right_valid_o = !flush_i && (state_q == StHold);
        dreq_valid_o  = (state_q == StReq);
    end

    assign capture = left_valid_i && left_ready_o;

    always_comb begin
        pc_d         = pc_q;
        inst_d       = inst_q;
        wreg_en_d    = wreg_en_q;
        wreg_index_d = wreg_index_q;
        result_d     = result_q;
        addr_d       = addr_q;
        ale_d        = ale_q;
        excp_d       = excp_q;
        ld_op_d      = ld_op_q;
        we_d         = we_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        if (capture) begin
            pc_d         = ex_pc_i;
            inst_d       = ex_inst_i;
            wreg_en_d    = ex_wreg_en_i && !ale;
            wreg_index_d = ex_wreg_index_i;
            result_d     = ex_result_i;
            addr_d       = ex_result_i;
            ale_d        = ale;
            excp_d       = ex_excp_i || ale;
            ld_op_d      = is_ld ? ex_ld_op_i : 3'd0;
            we_d         = is_st;
            wstrb_d      = st_wstrb;
            wdata_d      = st_wdata;
        end else if (state_q == StWait && dresp_valid_i && ld_op_q != 3'd0) begin
            result_d = ld_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q         <= 32'h0;
            inst_q       <= 32'h0;
            wreg_en_q    <= 1'b0;
            wreg_index_q <= 5'h0;
            result_q     <= 32'h0;
            addr_q       <= 32'h0;
            ale_q        <= 1'b0;
            excp_q       <= 1'b0;
            ld_op_q      <= 3'd0;
            we_q         <= 1'b0;
            wstrb_q      <= 4'h0;
            wdata_q      <= 32'h0;
        end else begin
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            wreg_en_q    <= wreg_en_d;
            wreg_index_q <= wreg_index_d;
            result_q     <= result_d;
            addr_q       <= addr_d;
            ale_q        <= ale_d;
            excp_q       <= excp_d;
            ld_op_q      <= ld_op_d;
            we_q         <= we_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
        end
    end

    assign dreq_we_o        = we_q;
    assign dreq_addr_o      = addr_q;
    assign dreq_wstrb_o     = wstrb_q;
    assign dreq_wdata_o     = wdata_q;
    assign mem_pc_o         = pc_q;
    assign mem_inst_o       = inst_q;
    assign mem_wreg_en_o    = wreg_en_q;
    assign mem_wreg_index_o = wreg_index_q;
    assign mem_result_o     = result_q;
    assign mem_addr_o       = addr_q;
    assign mem_ale_o        = ale_q;
    assign mem_excp_o       = excp_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: WB results and cache requests are predicted when
// stimulus is driven and compared when the DUT presents them.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, left_valid, left_ready;
    logic [31:0] ex_pc, ex_inst, ex_result, ex_st_data;
    logic        ex_wreg_en, ex_excp;
    logic [4:0]  ex_wreg_index;
    logic [2:0]  ex_ld_op;
    logic [1:0]  ex_st_op;
    logic        dreq_valid, dreq_ready, dreq_we;
    logic [31:0] dreq_addr, dreq_wdata;
    logic [3:0]  dreq_wstrb;
    logic        dresp_valid;
    logic [31:0] dresp_rdata;
    logic        right_valid, right_ready;
    logic [31:0] mem_pc, mem_inst, mem_result, mem_addr;
    logic        mem_wreg_en, mem_ale, mem_excp;
    logic [4:0]  mem_wreg_index;

    mem_stage dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .left_valid_i(left_valid), .left_ready_o(left_ready),
        .ex_pc_i(ex_pc), .ex_inst_i(ex_inst), .ex_wreg_en_i(ex_wreg_en),
        .ex_wreg_index_i(ex_wreg_index), .ex_result_i(ex_result), .ex_ld_op_i(ex_ld_op),
        .ex_st_op_i(ex_st_op), .ex_st_data_i(ex_st_data), .ex_excp_i(ex_excp),
        .dreq_valid_o(dreq_valid), .dreq_ready_i(dreq_ready), .dreq_we_o(dreq_we),
        .dreq_addr_o(dreq_addr), .dreq_wstrb_o(dreq_wstrb), .dreq_wdata_o(dreq_wdata),
        .dresp_valid_i(dresp_valid), .dresp_rdata_i(dresp_rdata),
        .right_valid_o(right_valid), .right_ready_i(right_ready),
        .mem_pc_o(mem_pc), .mem_inst_o(mem_inst), .mem_wreg_en_o(mem_wreg_en),
        .mem_wreg_index_o(mem_wreg_index), .mem_result_o(mem_result), .mem_addr_o(mem_addr),
        .mem_ale_o(mem_ale), .mem_excp_o(mem_excp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, result, addr;
        logic        wen, ale, excp;
        int          cap;
    } exp_t;
    typedef struct {
        logic        we;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  wstrb;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    int   n_cmp = 0, n_err = 0, n_wb = 0, last_lat = 0, cyc = 0, resp_delay = 1;
    logic [31:0] snap_pc, snap_res;
    logic [31:0] pat_bits;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] res,
                                input logic [31:0] addr, input logic wen, input logic ale,
                                input logic excp);
        exp_t e;
        e.pc = pc; e.result = res; e.addr = addr; e.wen = wen; e.ale = ale; e.excp = excp;
        e.cap = 0;
        return e;
    endfunction

    function automatic req_t mkreq(input logic we, input logic [31:0] addr,
                                   input logic [3:0] wstrb, input logic [31:0] wdata,
                                   input logic [31:0] rdata);
        req_t r;
        r.we = we; r.addr = addr; r.wstrb = wstrb; r.wdata = wdata; r.rdata = rdata;
        return r;
    endfunction

    // Drive one instruction until captured; called and returns at posedge+1
    task automatic send(input logic [31:0] pc, input logic [2:0] ld, input logic [1:0] st,
                        input logic [31:0] res, input logic [31:0] sd, input logic ex,
                        input exp_t e);
        left_valid = 1'b1; ex_pc = pc; ex_inst = pc ^ 32'hdead_0000; ex_wreg_en = 1'b1;
        ex_wreg_index = pc[4:0]; ex_result = res; ex_ld_op = ld; ex_st_op = st;
        ex_st_data = sd; ex_excp = ex;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (left_ready) begin
                e.cap = cyc + 1;
                exp_q.push_back(e);
                break;
            end
            if (n > 50) begin
                check_eq("send_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        left_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
            if (n > 100) begin
                check_eq(tag, exp_q.size(), 32'd0);
                exp_q.delete();
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // WB side monitor
    initial forever begin
        @(negedge clk);
        if (right_valid && right_ready) begin
            n_wb++;
            if (exp_q.size() == 0) begin
                check_eq("wb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                last_lat = cyc - e.cap + 1;
                check_eq("wb_pc", mem_pc, e.pc);
                check_eq("wb_inst", mem_inst, e.pc ^ 32'hdead_0000);
                check_eq("wb_idx", {27'h0, mem_wreg_index}, {27'h0, e.pc[4:0]});
                check_eq("wb_result", mem_result, e.result);
                check_eq("wb_addr", mem_addr, e.addr);
                check_eq("wb_flags", {29'h0, mem_wreg_en, mem_ale, mem_excp},
                         {29'h0, e.wen, e.ale, e.excp});
            end
        end
    end

    // Data cache model: one response per accepted request, resp_delay cycles later
    initial forever begin
        @(negedge clk);
        if (dreq_valid && dreq_ready) begin
            req_t r;
            r = mkreq(1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
            if (req_q.size() == 0) check_eq("req_unexpected", 32'd1, 32'd0);
            else begin
                r = req_q.pop_front();
                check_eq("req_we", {31'h0, dreq_we}, {31'h0, r.we});
                check_eq("req_addr", dreq_addr, r.addr);
                check_eq("req_wstrb", {28'h0, dreq_wstrb}, {28'h0, r.wstrb});
                if (r.we) check_eq("req_wdata", dreq_wdata, r.wdata);
            end
            @(posedge clk);
            repeat (resp_delay - 1) @(posedge clk);
            #1 dresp_valid = 1'b1; dresp_rdata = r.rdata;
            @(posedge clk);
            #1 dresp_valid = 1'b0; dresp_rdata = 32'h0;
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; left_valid = 1'b0; ex_pc = '0; ex_inst = '0;
        ex_wreg_en = 1'b0; ex_wreg_index = '0; ex_result = '0; ex_ld_op = '0; ex_st_op = '0;
        ex_st_data = '0; ex_excp = 1'b0; dreq_ready = 1'b1; dresp_valid = 1'b0;
        dresp_rdata = '0; right_ready = 1'b1;
        @(negedge clk);
        check_eq("rst_left_ready", {31'h0, left_ready}, 32'd1);
        check_eq("rst_valids", {30'h0, right_valid, dreq_valid}, 32'd0);
        check_eq("rst_mem_bus", mem_pc | mem_result | mem_addr | mem_inst, 32'd0);
        check_eq("rst_dreq_bus", dreq_addr | dreq_wdata | {28'h0, dreq_wstrb}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Sign- and zero-extended byte loads
        req_q.push_back(mkreq(1'b0, 32'h1003, 4'h0, 32'h0, 32'h80FF_FF7F));
        send(32'h100, 3'd1, 2'd0, 32'h1003, 32'h0, 1'b0,
             mk(32'h100, 32'hFFFF_FF80, 32'h1003, 1'b1, 1'b0, 1'b0));
        wait_empty("ldb_timeout");
        check_eq("ldb_latency", last_lat, 32'd3);
        req_q.push_back(mkreq(1'b0, 32'h1003, 4'h0, 32'h0, 32'h80FF_FF7F));
        send(32'h104, 3'd4, 2'd0, 32'h1003, 32'h0, 1'b0,
             mk(32'h104, 32'h0000_0080, 32'h1003, 1'b1, 1'b0, 1'b0));
        wait_empty("ldbu_timeout");
        check_eq("ldbu_latency", last_lat, 32'd3);

        // Halfword store at upper half
        req_q.push_back(mkreq(1'b1, 32'h2002, 4'b1100, 32'hABCD_ABCD, 32'h0));
        send(32'h108, 3'd0, 2'd2, 32'h2002, 32'h1234_ABCD, 1'b0,
             mk(32'h108, 32'h2002, 32'h2002, 1'b1, 1'b0, 1'b0));
        wait_empty("sth_timeout");

        // Misaligned word load: no cache access
        send(32'h10c, 3'd3, 2'd0, 32'h3001, 32'h0, 1'b0,
             mk(32'h10c, 32'h3001, 32'h3001, 1'b0, 1'b1, 1'b1));
        @(negedge clk);
        check_eq("ale_rv_dreq", {30'h0, right_valid, dreq_valid}, 32'd2);
        @(posedge clk); #1;
        wait_empty("ale_timeout");
        check_eq("ale_latency", last_lat, 32'd1);

        // Cache back-pressure: request held stable
        dreq_ready = 1'b0;
        req_q.push_back(mkreq(1'b0, 32'h4000, 4'h0, 32'h0, 32'h1357_9BDF));
        send(32'h110, 3'd3, 2'd0, 32'h4000, 32'h0, 1'b0,
             mk(32'h110, 32'h1357_9BDF, 32'h4000, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("stall_dreq_valid", {31'h0, dreq_valid}, 32'd1);
            check_eq("stall_dreq_addr", dreq_addr, 32'h4000);
            check_eq("stall_left_ready", {31'h0, left_ready}, 32'd0);
            @(posedge clk); #1;
        end
        dreq_ready = 1'b1;
        wait_empty("stall_timeout");

        // Flush while waiting: response must be drained and dropped
        resp_delay = 3;
        req_q.push_back(mkreq(1'b0, 32'h5000, 4'h0, 32'h0, 32'hCAFE_F00D));
        send(32'h114, 3'd3, 2'd0, 32'h5000, 32'h0, 1'b0,
             mk(32'h114, 32'hCAFE_F00D, 32'h5000, 1'b1, 1'b0, 1'b0));
        @(posedge clk); #1;
        flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_eq("flush_cycle_rdy_rv", {30'h0, left_ready, right_valid}, 32'd0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check_eq("drain_rdy_rv", {30'h0, left_ready, right_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("drain_resp_rdy", {30'h0, left_ready, right_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("drain_done_rdy", {31'h0, left_ready}, 32'd1);
        @(posedge clk); #1;
        resp_delay = 1;

        // Five back-to-back ALU ops with one WB stall cycle
        pat_bits = 32'b11101;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(32'h200 + 32'(4 * i), 3'd0, 2'd0, 32'hA000 + 32'(i), 32'h0, 1'b0,
                         mk(32'h200 + 32'(4 * i), 32'hA000 + 32'(i), 32'hA000 + 32'(i),
                            1'b1, 1'b0, 1'b0));
            end
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 5; i++) begin
                    right_ready = pat_bits[i];
                    @(negedge clk);
                    if (!pat_bits[i]) begin
                        snap_pc = mem_pc;
                        snap_res = mem_result;
                    end else if (i > 0 && !pat_bits[i-1]) begin
                        check_eq("hold_pc_stable", mem_pc, snap_pc);
                        check_eq("hold_res_stable", mem_result, snap_res);
                    end
                    @(posedge clk); #1;
                end
                right_ready = 1'b1;
            end
        join
        wait_empty("alu_timeout");

        check_eq("wb_total", n_wb, 32'd10);
        check_eq("req_leftover", req_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between EX and WB. Holds one instruction at a time and issues at most one data-cache request per load or store. Loads are sign- or zero-extended into a registered result; stores get their byte strobes and replicated write data generated here. Misaligned accesses are flagged as ALE without touching the cache. Downstream WB sees a plain valid/ready handshake; a flush kills the held instruction and any outstanding cache response is drained safely.

## Interface
- No parameters; all widths fixed.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  exception/ertn flush from WB; kills the held instruction
- left_valid  in  1  EX has an instruction
- left_ready  out  1  stage can capture this cycle
- ex_pc, ex_inst  in  32 each  PC and instruction word
- ex_wreg_en  in  1  register write enable
- ex_wreg_index  in  5  destination register
- ex_result  in  32  ALU result; effective address for memory ops
- ex_ld_op  in  3  0 none, 1 ld.b, 2 ld.h, 3 ld.w, 4 ld.bu, 5 ld.hu
- ex_st_op  in  2  0 none, 1 st.b, 2 st.h, 3 st.w
- ex_st_data  in  32  store source register value
- ex_excp  in  1  instruction already carries an exception; suppress memory access
- dreq_valid  out  1  cache request valid
- dreq_ready  in  1  cache accepts the request
- dreq_we  out  1  1 = store
- dreq_addr  out  32  request address, unaligned byte address
- dreq_wstrb  out  4  byte strobes, 0 for loads
- dreq_wdata  out  32  store data
- dresp_valid  in  1  response or write acknowledge; exactly one per accepted request, never in the acceptance cycle
- dresp_rdata  in  32  load word
- right_valid  out  1  result valid to WB
- right_ready  in  1  WB accepts
- mem_pc, mem_inst  out  32 each  held copies
- mem_wreg_en  out  1  held copy, forced 0 when mem_ale = 1
- mem_wreg_index  out  5  held copy
- mem_result  out  32  extended load data, or ex_result for non-loads
- mem_addr  out  32  effective address (used as badv)
- mem_ale  out  1  misalignment exception
- mem_excp  out  1  ex_excp passthrough OR mem_ale

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN. Payload is captured on left_valid & left_ready.
- Target state after capture:
  - REQ when the instruction is a memory op with ex_excp = 0 and ale = 0.
  - HOLD otherwise.
- Alignment (ale):
  - h-ops (ld.h, ld.hu, st.h): ale when addr[0] = 1.
  - w-ops (ld.w, st.w): ale when addr[1:0] != 0.
  - b-ops are never misaligned.
- left_ready = IDLE | (HOLD & right_ready); it is 0 whenever flush = 1.
- REQ:
  - dreq_valid = 1, with addr, we, wstrb and wdata stable until dreq_ready.
  - dreq_ready → WAIT.
- WAIT: dresp_valid → HOLD. For loads, mem_result is loaded with extracted data.
- Load extraction, using offset addr[1:0]:
  - b/bu: byte at offset, sign- or zero-extended.
  - h/hu: half at addr[1], sign- or zero-extended.
  - w: the full word.
- Store encoding:
  - st.b: wstrb = 4'b0001 << addr[1:0], wdata = {4{data[7:0]}}.
  - st.h: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}.
  - st.w: wstrb = 4'b1111, wdata = data.
- HOLD: right_valid = 1. On right_ready, capture a new instruction if left_valid, otherwise go to IDLE.
- Flush has priority over every other transition:
  - From WAIT, or from REQ with dreq_ready = 1 in the same cycle → DRAIN.
  - From any other state → IDLE.
  - right_valid is forced 0 during the flush cycle.
- DRAIN: left_ready = 0, right_valid = 0. On dresp_valid the response is discarded → IDLE.
- dreq_valid is 0 outside REQ. right_valid is 0 outside HOLD.

## Timing
- Reset values:
  - State IDLE.
  - All registered outputs 0: mem_* buses, right_valid, dreq_valid, dreq_we, dreq_wstrb, dreq_addr, dreq_wdata.
  - left_ready = 1.
- Non-memory op or ALE: capture at edge N, right_valid high in the cycle after N. Latency 1.
- Load or store with dreq_ready = 1 in the REQ cycle and dresp_valid on the next cycle: REQ at N+1, WAIT at N+2, HOLD at N+3. Latency 3.
- Back-to-back non-memory ops with right_ready held at 1 sustain 1 instruction per cycle.
- The HOLD payload is stable while right_ready = 0.
- A request is never withdrawn once dreq_valid is asserted, except by flush in REQ without dreq_ready.
- Reset mid-operation drops every state immediately. The cache side must be reset concurrently.

## Test plan
- ld.b at addr 0x1003, dresp_rdata 0x80FF_FF7F → mem_result 0xFFFF_FF80. Same case with ld.bu → 0x0000_0080. Latency 3 cycles.
- st.h at addr 0x2002, data 0x1234_ABCD → dreq_wstrb 4'b1100, dreq_wdata 0xABCD_ABCD, dreq_we = 1. Completes after dresp_valid.
- ld.w at addr 0x3001 → no dreq_valid, mem_ale = 1, mem_excp = 1, mem_wreg_en = 0, mem_addr 0x3001, right_valid 1 cycle after capture.
- dreq_ready held 0 for 4 cycles → dreq_valid and dreq_addr stable throughout; left_ready = 0.
- flush in WAIT, with dresp_valid 2 cycles later → DRAIN; response discarded; right_valid never asserted; left_ready returns to 1 the cycle after dresp_valid.
- 5 back-to-back ALU ops, right_ready toggling 1,0,1,1,1 → results emitted in order, none lost or duplicated, payload unchanged during the stall.
